// File: rtl/seg_decoder_pkg.sv
// Types and helpers for the seven-segment loopback decoder.
// Pure definitions: no latency, no flow control.
package seg_decoder_pkg;
  `include "seg_defs.vh"

  localparam int SEG_W = 9;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    LOCKED = ST_LOCKED
  } state_t;

  typedef struct packed {
    logic [SEG_W-1:0] seg1;
    logic [SEG_W-1:0] seg2;
  } pat_t;

  function automatic logic is_blank(input logic [SEG_W-1:0] seg);
    return seg[SEG_DIG] || (seg[6:0] == 7'd0);
  endfunction
endpackage

// File: rtl/seg_decoder_if.sv
// Segment buses in, recovered display content out.
// Observation only: the decoder never stalls the display path.
interface seg_decoder_if;
  logic [8:0] seg1;
  logic [8:0] seg2;
  logic [7:0] value;
  logic       value_valid;
  logic [1:0] dp;
  logic [1:0] blank;
  logic       err;
  logic [7:0] upd_cnt;
  logic [7:0] err_cnt;

  modport master (
    output seg1, seg2,
    input  value, value_valid, dp, blank, err, upd_cnt, err_cnt
  );

  modport slave (
    input  seg1, seg2,
    output value, value_valid, dp, blank, err, upd_cnt, err_cnt
  );
endinterface

// File: rtl/seg_defs.vh
// Segment bus bit positions, hex glyph codes and decoder state encodings.
// Shared with the display driver so both ends agree on every glyph.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH
localparam int SEG_DP  = 7;
localparam int SEG_DIG = 8;

localparam logic [6:0] GLYPH_0 = 7'h3F;
localparam logic [6:0] GLYPH_1 = 7'h06;
localparam logic [6:0] GLYPH_2 = 7'h5B;
localparam logic [6:0] GLYPH_3 = 7'h4F;
localparam logic [6:0] GLYPH_4 = 7'h66;
localparam logic [6:0] GLYPH_5 = 7'h6D;
localparam logic [6:0] GLYPH_6 = 7'h7D;
localparam logic [6:0] GLYPH_7 = 7'h07;
localparam logic [6:0] GLYPH_8 = 7'h7F;
localparam logic [6:0] GLYPH_9 = 7'h6F;
localparam logic [6:0] GLYPH_A = 7'h77;
localparam logic [6:0] GLYPH_B = 7'h7C;
localparam logic [6:0] GLYPH_C = 7'h39;
localparam logic [6:0] GLYPH_D = 7'h5E;
localparam logic [6:0] GLYPH_E = 7'h79;
localparam logic [6:0] GLYPH_F = 7'h71;

localparam logic [1:0] ST_IDLE   = 2'd0;
localparam logic [1:0] ST_SETTLE = 2'd1;
localparam logic [1:0] ST_LOCKED = 2'd2;
`endif

// File: rtl/seg_glyph_lut.sv
// Combinational 7-segment glyph to hex nibble lookup, hit=0 for unknown glyphs.
// Zero latency, no flow control.
module seg_glyph_lut
  import seg_decoder_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (glyph)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Recovers the displayed byte from two seven-segment buses after STABLE_CYCLES equal samples.
// Commit lands STABLE_CYCLES edges after the first sampling edge; no backpressure, pulses are one cycle.
module seg_decoder
  import seg_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  seg_decoder_if.slave   bus
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  state_t     state, state_nxt;
  pat_t       sample, seg_q, last_pat;
  logic       last_vld;
  logic [7:0] cnt, cnt_nxt;
  logic       same, commit;

  logic       blank_hi, blank_lo, hit_hi, hit_lo;
  logic [3:0] lut_hi, lut_lo;
  logic       bad, dup;

  logic [7:0] value_r, upd_cnt_r, err_cnt_r;
  logic [1:0] dp_r, blank_r;
  logic       value_valid_r, err_r;

  assign sample = {bus.seg1, bus.seg2};
  assign same   = (sample == seg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      seg_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      seg_q <= sample;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt   = 8'd0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!same) begin
          cnt_nxt = 8'd0;
        end else if (cnt == LAST_CNT) begin
          commit    = 1'b1;
          state_nxt = LOCKED;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      LOCKED: begin
        if (!same) begin
          cnt_nxt   = 8'd0;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode seg_q: at commit it equals the current sample, and it is already registered.
  seg_glyph_lut u_lut_hi (.glyph(seg_q.seg1[6:0]), .hit(hit_hi), .nibble(lut_hi));
  seg_glyph_lut u_lut_lo (.glyph(seg_q.seg2[6:0]), .hit(hit_lo), .nibble(lut_lo));

  assign blank_hi = is_blank(seg_q.seg1);
  assign blank_lo = is_blank(seg_q.seg2);
  assign bad      = (!blank_hi && !hit_hi) || (!blank_lo && !hit_lo);
  assign dup      = last_vld && (last_pat == seg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pat      <= '0;
      last_vld      <= 1'b0;
      value_r       <= 8'd0;
      dp_r          <= 2'b00;
      blank_r       <= 2'b00;
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      upd_cnt_r     <= 8'd0;
      err_cnt_r     <= 8'd0;
    end else begin
      value_valid_r <= 1'b0;
      err_r         <= 1'b0;
      if (commit) begin
        // Error commits are remembered too, so a stuck bad glyph reports once.
        last_pat <= seg_q;
        last_vld <= 1'b1;
        if (!dup) begin
          if (bad) begin
            err_r <= 1'b1;
            if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
          end else begin
            value_valid_r <= 1'b1;
            value_r       <= {(blank_hi ? 4'h0 : lut_hi), (blank_lo ? 4'h0 : lut_lo)};
            dp_r          <= {seg_q.seg1[SEG_DP], seg_q.seg2[SEG_DP]};
            blank_r       <= {blank_hi, blank_lo};
            upd_cnt_r     <= upd_cnt_r + 8'd1;
          end
        end
      end
    end
  end

  assign bus.value       = value_r;
  assign bus.value_valid = value_valid_r;
  assign bus.dp          = dp_r;
  assign bus.blank       = blank_r;
  assign bus.err         = err_r;
  assign bus.upd_cnt     = upd_cnt_r;
  assign bus.err_cnt     = err_cnt_r;

endmodule
